// File: rtl/combat_status_pkg.sv
// Shared constants for the combat status block and the stage controller:
// stage codes, kills-per-stage target step and the combat state encoding.
package combat_status_pkg;

  localparam logic [3:0] STAGE_TITLE = 4'h0;
  localparam logic [3:0] STAGE_1     = 4'h1;
  localparam logic [3:0] STAGE_2     = 4'h2;
  localparam logic [3:0] STAGE_3     = 4'h3;
  localparam logic [3:0] STAGE_4     = 4'h4;
  localparam logic [3:0] STAGE_WIN   = 4'hE;
  localparam logic [3:0] STAGE_OVER  = 4'hF;

  localparam int KILLS_PER_STAGE = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } combat_state_t;

  function automatic logic is_play_stage(input logic [3:0] stage);
    return (stage >= STAGE_1) && (stage <= STAGE_4);
  endfunction

endpackage

// File: rtl/combat_status_if.sv
// Bundle between the stage controller / collision logic (master) and the
// combat status block (slave).
interface combat_status_if;
  logic [3:0] stage;
  logic       changing_stage;
  logic       enemy_hit;
  logic       player_hit;
  logic [3:0] kills;
  logic       gameover;
  logic [2:0] hp;
  logic       invuln;

  modport master (
    output stage, changing_stage, enemy_hit, player_hit,
    input  kills, gameover, hp, invuln
  );

  modport slave (
    input  stage, changing_stage, enemy_hit, player_hit,
    output kills, gameover, hp, invuln
  );
endinterface

// File: rtl/combat_status_invuln_timer.sv
// Loadable 8-bit down-counter for the post-hit invulnerability window;
// done pulses on the last counting cycle (count about to reach zero).
module combat_status_invuln_timer #(
  parameter int LOAD_VALUE = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic active,
  output logic done
);

  logic [7:0] count_r;

  // Down-counter; clear wins over load so a stage change always cancels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (load) begin
      count_r <= 8'(LOAD_VALUE);
    end else if (count_r != 8'd0) begin
      count_r <= count_r - 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign active = (count_r != 8'd0);
  assign done   = (count_r == 8'd1);

endmodule

// File: rtl/combat_status.sv
// Kill count, player HP, invulnerability and gameover tracking.
// Optional build macro STAGE_HEAL_EN: +1 HP (capped) on entering a play stage.
module combat_status #(
  parameter int MAX_HP          = 3,
  parameter int KILLS_PER_STAGE = 2,
  parameter int INVULN_CYCLES   = 50
) (
  input  logic            clk,
  input  logic            rst,
  combat_status_if.slave  bus
);
  import combat_status_pkg::*;

  localparam logic [2:0] HP_FULL = 3'(MAX_HP);
  localparam logic [3:0] KPS4    = 4'(KILLS_PER_STAGE);

  combat_state_t state_r;
  logic [3:0]    kills_r;
  logic [2:0]    hp_r;
  logic          gameover_r;
  logic          invuln_r;

  logic       stage_play;
  logic [3:0] target;
  logic       in_combat;
  logic       stage_change;
  logic       active_play;
  logic       kill_ok;
  logic       hit_taken;
  logic       hit_fatal;
  logic       hit_survived;
  logic       timer_load;
  logic       timer_clear;
  logic       timer_active;
  logic       timer_done;

  // Input decode; a stage change masks every hit in the same cycle.
  always_comb begin
    stage_play   = is_play_stage(bus.stage);
    target       = bus.stage * KPS4;
    in_combat    = (state_r == PLAY) || (state_r == INVULN);
    stage_change = in_combat && bus.changing_stage;
    active_play  = in_combat && !bus.changing_stage && stage_play;
    kill_ok      = active_play && bus.enemy_hit && (kills_r < target);
    hit_taken    = active_play && bus.player_hit && (state_r == PLAY);
    hit_fatal    = hit_taken && (hp_r <= 3'd1);
    hit_survived = hit_taken && (hp_r > 3'd1);
    timer_load   = hit_survived;
    timer_clear  = in_combat && (bus.changing_stage || !stage_play);
  end

  combat_status_invuln_timer #(
    .LOAD_VALUE (INVULN_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .clear  (timer_clear),
    .active (timer_active),
    .done   (timer_done)
  );

  // Combat state machine; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      kills_r    <= 4'd0;
      hp_r       <= HP_FULL;
      gameover_r <= 1'b0;
      invuln_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.stage == STAGE_TITLE) begin
            kills_r    <= 4'd0;
            hp_r       <= HP_FULL;
            gameover_r <= 1'b0;
          end else if (stage_play) begin
            state_r <= PLAY;
          end
        end
        PLAY, INVULN: begin
          if (stage_change) begin
            invuln_r <= 1'b0;
            state_r  <= stage_play ? PLAY : IDLE;
`ifdef STAGE_HEAL_EN
            if (stage_play && (hp_r < HP_FULL)) begin
              hp_r <= hp_r + 3'd1;
            end
`endif
          end else if (!stage_play) begin
            invuln_r <= 1'b0;
            state_r  <= IDLE;
          end else begin
            if (kill_ok) begin
              kills_r <= kills_r + 4'd1;
            end
            if (hit_fatal) begin
              hp_r       <= 3'd0;
              gameover_r <= 1'b1;
              invuln_r   <= 1'b0;
              state_r    <= DEAD;
            end else if (hit_survived) begin
              hp_r     <= hp_r - 3'd1;
              invuln_r <= 1'b1;
              state_r  <= INVULN;
            end else if ((state_r == INVULN) && (timer_done || !timer_active)) begin
              invuln_r <= 1'b0;
              state_r  <= PLAY;
            end
          end
        end
        DEAD: begin
          if (bus.stage == STAGE_TITLE) begin
            kills_r    <= 4'd0;
            hp_r       <= HP_FULL;
            gameover_r <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.kills    = kills_r;
  assign bus.hp       = hp_r;
  assign bus.gameover = gameover_r;
  assign bus.invuln   = invuln_r;

endmodule

// File: doc/combat_status.md
Name: combat_status

Overview:
- Produces the `kills` count and `gameover` flag that the stage controller consumes.
- Consumes the controller's `stage` and `changing_stage` outputs, plus one-cycle hit pulses from the collision logic.
- Tracks cumulative kills, with a cap per stage.
- Tracks player HP and a post-hit invulnerability window.
- Sits between the collision logic and the stage controller; its outputs also feed the HUD/display.

Parameters:
- MAX_HP, 3, starting and maximum player HP (1..7).
- KILLS_PER_STAGE, 2, kills required per stage; the cumulative target for stage N is N*KILLS_PER_STAGE.
- INVULN_CYCLES, 50, cycles of invulnerability after a player hit (1..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- stage  input  4  current stage code: 0 title, 1..4 play, E win, F game over.
- changing_stage  input  1  one-cycle pulse; asserted the cycle after the controller changes stage.
- enemy_hit  input  1  one-cycle pulse; player destroyed an enemy.
- player_hit  input  1  one-cycle pulse; player took a hit.
- kills  output  4  cumulative kill count since the title screen.
- gameover  output  1  level; player HP exhausted.
- hp  output  3  current player HP.
- invuln  output  1  high while the invulnerability window is active (drives sprite blink).

Behaviour:
- All outputs are registered. An input pulse at edge k is reflected in outputs after edge k.
- Reset (async): state=IDLE, kills=0, hp=MAX_HP, gameover=0, invuln=0, invulnerability counter=0.
- "Play stage" means stage is in 1..4. "target" means stage*KILLS_PER_STAGE, computed 4-bit; it is valid only in play stages.
- State IDLE:
  - If stage==0: kills<=0, hp<=MAX_HP, gameover<=0.
  - If stage==E: hold kills and hp (for win-screen display).
  - Go to PLAY when a play stage is seen.
- State PLAY:
  - enemy_hit with kills<target: kills+1.
  - enemy_hit with kills==target: ignored. This saturates kills so the controller's equality-based countdown holds.
  - player_hit with hp>1: hp-1, load counter with INVULN_CYCLES, go to INVULN.
  - player_hit with hp==1: hp<=0, gameover<=1, go to DEAD.
- State INVULN:
  - invuln=1.
  - player_hit is ignored. enemy_hit is handled as in PLAY.
  - Counter decrements each cycle. When it reaches 0: invuln<=0, go to PLAY.
- State DEAD:
  - gameover=1 and kills are frozen.
  - enemy_hit and player_hit are ignored.
  - Go to IDLE only when stage==0; the IDLE stage==0 clear applies on that transition.
- Stage change (changing_stage==1 in PLAY/INVULN):
  - Hits in that cycle are ignored.
  - The invulnerability counter clears, invuln<=0.
  - If the new stage is a play stage, go to PLAY; otherwise go to IDLE.
- Simultaneous enemy_hit and player_hit in PLAY: both are applied in the same cycle.
  - If the player hit is fatal, gameover=1 takes priority, matching the controller's gameover-first check.
- Stage value outside 0..4, E, F while in PLAY: treat as non-play and go to IDLE, holding all counts.
- kills never exceeds 4*KILLS_PER_STAGE. The 4-bit kills output has no wrap-around.
- Reset mid-operation: returns immediately to reset values, whatever the state.

Optional Feature:
- Macro: STAGE_HEAL_EN.
- Defined: on changing_stage into a play stage, hp<=min(hp+1, MAX_HP), applied in the same edge as the other stage-change actions.
- Undefined: hp carries over unchanged between stages; it is refilled only by the stage==0 clear.

Decomposition:
- Shared package:
  - Stage code constants: STAGE_TITLE=4'h0, STAGE_1..STAGE_4, STAGE_WIN=4'hE, STAGE_OVER=4'hF.
  - KILLS_PER_STAGE.
  - combat state enum: IDLE, PLAY, INVULN, DEAD.
  - These constants are shared with the stage controller.
- Sub-module: invuln_timer.
  - Loadable 8-bit down-counter with `load` and `clear` inputs.
  - Outputs `active` and a `done` pulse.

Test Plan:
1. Reset then stage=1; pulse enemy_hit 3 times -> kills=1, 2, 2 (third hit saturated); hp=3; gameover=0.
2. stage=2 with kills=2; one enemy_hit and player_hit in the same cycle -> kills=3, hp=2, invuln=1 for exactly 50 cycles. A player_hit 10 cycles later -> ignored (hp stays 2).
3. stage=1, hp=1; player_hit and enemy_hit in the same cycle with kills=1 -> hp=0, gameover=1, kills=2. Then stage=F, further hits -> all outputs unchanged. Then stage=0 -> kills=0, hp=3, gameover=0 next cycle.
4. In INVULN with 20 cycles left, pulse changing_stage with stage=3 -> invuln=0 next cycle, state PLAY. A player_hit in the changing_stage cycle -> ignored.
5. stage=4, reach kills=8, then stage=E -> kills holds 8, hp held. Then stage=0 -> kills=0.
6. With STAGE_HEAL_EN: hp=1, changing_stage into stage 2 -> hp=2. At hp=3 -> hp stays 3. Without the macro, hp stays 1 in the same scenario.
